// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Used by both the parity transmitter and the parity checker.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_parity_tx_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
// The master drives data/valid; the slave returns ready, which is high only when idle.
interface uart_parity_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_parity_tx_parity_gen.sv
// Combinational parity bit for one data byte; zero latency, no flow control.
// The checker side instantiates the same module so both ends agree on polarity.
module parity_gen
    import uart_pkg::*;
#(
    parameter int PARITY_ODD = 0
) (
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 parity_o
);
    assign parity_o = (^data_i) ^ (PARITY_ODD != 0);
endmodule

// File: rtl/uart_parity_tx.sv
// UART frame serializer (start, 8 data LSB-first, parity, stop); line goes low 1 cycle after accept.
// Ready only in IDLE: requests during a frame are ignored, nothing is queued.
module uart_parity_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_parity_tx_if.slave      tx,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic [DATA_BITS:0]   tx_frame,
    output logic                 tx_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);

    state_t               state_q;
    logic [BW-1:0]        baud_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS:0]   frame_q;
    logic                 serial_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 parity_d;
    logic                 bit_end;

    parity_gen #(.PARITY_ODD(PARITY_ODD)) u_parity (
        .data_i   (tx.tx_data),
        .parity_o (parity_d)
    );

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            frame_q  <= '0;
            serial_q <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    serial_q <= 1'b1;
                    if (tx.tx_valid && ready_q) begin
                        shift_q  <= tx.tx_data;
                        frame_q  <= {parity_d, tx.tx_data};
                        baud_q   <= '0;
                        bit_q    <= '0;
                        serial_q <= 1'b0;
                        ready_q  <= 1'b0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            serial_q <= frame_q[DATA_BITS];
                            state_q  <= PARITY;
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            shift_q  <= shift_q >> 1;
                            serial_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        baud_q   <= '0;
                        serial_q <= 1'b1;
                        state_q  <= STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                        // Registered pulse: armed one cycle early so it lands on the last stop cycle.
                        if (baud_q == BAUD_PRE) done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx.tx_ready = ready_q;
    assign tx_busy     = ~ready_q;
    assign tx_serial   = serial_q;
    assign tx_frame    = frame_q;
    assign tx_done     = done_q;
endmodule

// File: tb/tb_uart_parity_tx.sv
// Self-checking bench: vector table plus hand sequences, serial-line scoreboard on the even-parity DUT.
module tb_uart_parity_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_e, busy_e, done_e;
    logic [8:0] frame_e;
    logic       ser_o, busy_o, done_o;
    logic [8:0] frame_o;

    int checks   = 0;
    int failures = 0;
    int frames_rx = 0;

    logic [8:0]  exp_q[$];
    logic        mon_active = 1'b0;
    int          mon_cnt = 0;
    logic [10:0] rx_bits;
    logic [8:0]  exp_f;

    uart_parity_tx_if ife ();
    uart_parity_tx_if ifo ();

    uart_parity_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .tx(ife),
        .tx_serial(ser_e), .tx_busy(busy_e), .tx_frame(frame_e), .tx_done(done_e)
    );
    uart_parity_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .tx(ifo),
        .tx_serial(ser_o), .tx_busy(busy_o), .tx_frame(frame_o), .tx_done(done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Line monitor: samples each bit at its centre and compares against the queued frame.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
            mon_cnt    = 0;
            exp_q.delete();
        end else if (!mon_active) begin
            if (ser_e === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2) rx_bits[mon_cnt / CPB] = ser_e;
            if (mon_cnt == 10 * CPB + CPB / 2) begin
                mon_active = 1'b0;
                if (exp_q.size() == 0) begin
                    check("rx_unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_f = exp_q.pop_front();
                    check("rx_start", {31'd0, rx_bits[0]}, 32'd0);
                    check("rx_data", {24'd0, rx_bits[8:1]}, {24'd0, exp_f[7:0]});
                    check("rx_parity", {31'd0, rx_bits[9]}, {31'd0, exp_f[8]});
                    check("rx_stop", {31'd0, rx_bits[10]}, 32'd1);
                end
                frames_rx++;
            end
        end
    end

    task automatic wait_ready_e();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ife.tx_ready) break;
        end
        check("ready_wait_e", {31'd0, ife.tx_ready}, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic [8:0] ef);
        int done_at;
        int pulses;
        wait_ready_e();
        ife.tx_data  = d;
        ife.tx_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(ef);
        #1;
        ife.tx_valid = 1'b0;
        ife.tx_data  = ~d;
        done_at = 0;
        pulses  = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("start_low_latency1", {31'd0, ser_e}, 32'd0);
                check("busy_after_accept", {31'd0, busy_e}, 32'd1);
                check("ready_low_in_frame", {31'd0, ife.tx_ready}, 32'd0);
            end
            if (done_e === 1'b1) begin
                pulses++;
                if (done_at == 0) done_at = c;
            end
        end
        check("tx_frame", {23'd0, frame_e}, {23'd0, ef});
        check("checker_data", {24'd0, frame_e[7:0]}, {24'd0, d});
        check("checker_parity_ok", {31'd0, ^frame_e}, 32'd0);
        check("done_cycle", done_at, 44);
        check("done_pulses", pulses, 1);
        check("ready_after_frame", {31'd0, ife.tx_ready}, 32'd1);
        check("busy_after_frame", {31'd0, busy_e}, 32'd0);
    endtask

    task automatic send_odd(input logic [7:0] d, input logic [8:0] ef);
        int done_at;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ifo.tx_ready) break;
        end
        check("ready_wait_o", {31'd0, ifo.tx_ready}, 32'd1);
        ifo.tx_data  = d;
        ifo.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        ifo.tx_valid = 1'b0;
        done_at = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) check("odd_frame", {23'd0, frame_o}, {23'd0, ef});
            if (c == 38) check("odd_parity_line", {31'd0, ser_o}, {31'd0, ef[8]});
            if (done_o === 1'b1 && done_at == 0) done_at = c;
        end
        check("odd_done_cycle", done_at, 44);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [8:0] frame;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   base;
        int   pulses;
        vecs[0] = '{8'hBF, 9'h1BF};
        vecs[1] = '{8'h0F, 9'h00F};
        vecs[2] = '{8'h4F, 9'h14F};
        vecs[3] = '{8'h00, 9'h000};

        // Reset with valid asserted on both DUTs.
        rst = 1'b1;
        ife.tx_valid = 1'b1; ife.tx_data = 8'hBF;
        ifo.tx_valid = 1'b1; ifo.tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_serial", {31'd0, ser_e}, 32'd1);
        check("rst_ready", {31'd0, ife.tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy_e}, 32'd0);
        check("rst_done", {31'd0, done_e}, 32'd0);
        check("rst_frame", {23'd0, frame_e}, 32'd0);
        rst = 1'b0;
        ife.tx_valid = 1'b0;
        ifo.tx_valid = 1'b0;
        @(negedge clk);
        check("no_accept_in_rst", {31'd0, busy_e}, 32'd0);
        check("no_accept_in_rst_o", {31'd0, busy_o}, 32'd0);
        check("idle_serial", {31'd0, ser_e}, 32'd1);

        for (int i = 0; i < 4; i++) send(vecs[i].data, vecs[i].frame);

        // Back-to-back with tx_valid held high.
        base = frames_rx;
        wait_ready_e();
        ife.tx_data = 8'hA5; ife.tx_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(9'h0A5);
        #1 ife.tx_data = 8'h3C;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) check("b2b_first_start", {31'd0, ser_e}, 32'd0);
            if (c == 20) check("b2b_no_midframe_take", {23'd0, frame_e}, 32'h0A5);
            if (c == 45) begin
                check("b2b_idle_gap", {31'd0, ser_e}, 32'd1);
                check("b2b_ready_gap", {31'd0, ife.tx_ready}, 32'd1);
            end
        end
        @(posedge clk);
        exp_q.push_back(9'h03C);
        #1 ife.tx_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_start_46", {31'd0, ser_e}, 32'd0);
        check("b2b_second_frame", {23'd0, frame_e}, 32'h03C);
        for (int c = 47; c <= 100; c++) @(negedge clk);
        check("b2b_two_frames", frames_rx - base, 2);
        check("b2b_idle_after", {31'd0, ife.tx_ready}, 32'd1);

        // Reset during data bit 3 of 0xFF.
        wait_ready_e();
        ife.tx_data = 8'hFF; ife.tx_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(9'h0FF);
        #1 ife.tx_valid = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (done_e === 1'b1) pulses++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (done_e === 1'b1) pulses++;
        check("abort_serial", {31'd0, ser_e}, 32'd1);
        check("abort_ready", {31'd0, ife.tx_ready}, 32'd1);
        check("abort_frame_cleared", {23'd0, frame_e}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done_e === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        send(8'h01, 9'h101);

        // Odd parity instance.
        send_odd(8'h00, 9'h100);
        send_odd(8'hFF, 9'h1FF);

        check("scoreboard_empty", exp_q.size(), 0);
        check("frames_total", frames_rx, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
